// File: rtl/color_palette_db.sv
// color_palette_db: double-buffered RGB palette. Avalon-MM edits the shadow bank,
// and a pending commit copies it into the active (lookup) bank at frame_start.
module color_palette_db #(
  parameter int unsigned NUM_PALETTES       = 8,
  parameter int unsigned COLORS_PER_PALETTE = 4,
  parameter int unsigned CHANNEL_W          = 8,
  localparam int unsigned PAL_W   = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1,
  localparam int unsigned IDX_W   = $clog2(COLORS_PER_PALETTE),
  localparam int unsigned COLOR_W = 3 * CHANNEL_W,
  localparam int unsigned ADDR_W  = PAL_W + IDX_W + 1
) (
  input  logic               CLK_100,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  AVL_ADDR,
  input  logic [31:0]        AVL_WRITEDATA,
  input  logic [3:0]         AVL_BYTE_EN,
  output logic [31:0]        AVL_READDATA,
  input  logic               AVL_WRITE,
  input  logic               AVL_READ,
  input  logic               AVL_CS,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PAL_W-1:0]   palette,
  input  logic [IDX_W-1:0]   color_index,
  output logic [COLOR_W-1:0] rgb,
  output logic               rgb_valid,
  output logic               rgb_transparent,
  output logic               commit_done
);

  localparam int unsigned OFF_W = ADDR_W - 1;

  logic [COLOR_W-1:0] shadow [NUM_PALETTES][COLORS_PER_PALETTE];
  logic [COLOR_W-1:0] active [NUM_PALETTES][COLORS_PER_PALETTE];
  logic               pending;
  logic               trans_en;
  logic [7:0]         commit_count;

  logic               is_ctrl_c;
  logic [OFF_W-1:0]   ctrl_off_c;
  logic [PAL_W-1:0]   avl_pal_c;
  logic [IDX_W-1:0]   avl_idx_c;
  logic               avl_pal_ok_c;
  logic               pix_pal_ok_c;
  logic               entry_wr_c;
  logic               ctrl_wr_c;
  logic               rd_en_c;
  logic               commit_c;
  logic [COLOR_W-1:0] wmask_c;
  logic [COLOR_W-1:0] wdata_c;
  logic [COLOR_W-1:0] entry_rd_c;
  logic [COLOR_W-1:0] lookup_c;
  logic [31:0]        rd_data_c;

  // Byte-lane enables expand to a per-bit mask over the colour field only.
  for (genvar b = 0; b < COLOR_W; b++) begin : g_wmask
    assign wmask_c[b] = AVL_BYTE_EN[b / 8];
  end

  // Address decode, read mux and lookup mux.
  always_comb begin
    is_ctrl_c    = AVL_ADDR[ADDR_W-1];
    ctrl_off_c   = AVL_ADDR[OFF_W-1:0];
    avl_pal_c    = AVL_ADDR[IDX_W +: PAL_W];
    avl_idx_c    = AVL_ADDR[IDX_W-1:0];
    avl_pal_ok_c = 32'(avl_pal_c) < NUM_PALETTES;
    pix_pal_ok_c = 32'(palette) < NUM_PALETTES;
    entry_wr_c   = AVL_CS & AVL_WRITE & ~is_ctrl_c & avl_pal_ok_c;
    ctrl_wr_c    = AVL_CS & AVL_WRITE & is_ctrl_c & (ctrl_off_c == '0) & AVL_BYTE_EN[0];
    rd_en_c      = AVL_CS & AVL_READ & ~AVL_WRITE;
    commit_c     = frame_start & pending;
    wdata_c      = AVL_WRITEDATA[COLOR_W-1:0];

    entry_rd_c = '0;
    if (avl_pal_ok_c) begin
      entry_rd_c = shadow[avl_pal_c][avl_idx_c];
    end

    lookup_c = '0;
    if (pix_pal_ok_c) begin
      lookup_c = active[palette][color_index];
    end

    rd_data_c = '0;
    if (!is_ctrl_c) begin
      rd_data_c = 32'(entry_rd_c);
    end else if (ctrl_off_c == '0) begin
      rd_data_c = {30'b0, trans_en, pending};
    end else if (ctrl_off_c == OFF_W'(1)) begin
      rd_data_c = {24'b0, commit_count};
    end
  end

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      shadow          <= '{default: '0};
      active          <= '{default: '0};
      pending         <= 1'b0;
      trans_en        <= 1'b0;
      commit_count    <= 8'd0;
      commit_done     <= 1'b0;
      AVL_READDATA    <= 32'd0;
      rgb             <= '0;
      rgb_valid       <= 1'b0;
      rgb_transparent <= 1'b0;
    end else begin
      if (entry_wr_c) begin
        shadow[avl_pal_c][avl_idx_c] <= (entry_rd_c & ~wmask_c) | (wdata_c & wmask_c);
      end

      // Non-blocking copy sees the shadow as it stood before any same-cycle write.
      if (commit_c) begin
        active       <= shadow;
        commit_count <= commit_count + 8'd1;
      end
      commit_done <= commit_c;

      // A request landing with frame_start survives into the next frame.
      if (ctrl_wr_c && AVL_WRITEDATA[0]) begin
        pending <= 1'b1;
      end else if (commit_c) begin
        pending <= 1'b0;
      end

      if (ctrl_wr_c) begin
        trans_en <= AVL_WRITEDATA[1];
      end

      if (rd_en_c) begin
        AVL_READDATA <= rd_data_c;
      end

      rgb_valid <= pix_valid;
      if (pix_valid) begin
        rgb             <= lookup_c;
        rgb_transparent <= trans_en & (color_index == '0);
      end
    end
  end

endmodule

// File: tb/tb_color_palette_db.sv
// Bench for color_palette_db: directed scenarios plus random traffic checked
// against a transaction-level palette model.
module tb_color_palette_db;

  localparam int unsigned NP = 8;
  localparam int unsigned NC = 4;

  logic        CLK_100 = 1'b0;
  logic        RESET;
  logic [5:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic [3:0]  AVL_BYTE_EN;
  logic [31:0] AVL_READDATA;
  logic        AVL_WRITE;
  logic        AVL_READ;
  logic        AVL_CS;
  logic        frame_start;
  logic        pix_valid;
  logic [2:0]  palette;
  logic [1:0]  color_index;
  logic [23:0] rgb;
  logic        rgb_valid;
  logic        rgb_transparent;
  logic        commit_done;

  logic [31:0] rd5;
  logic [23:0] rgb5;
  logic        rgb_valid5;
  logic        trans5;
  logic        done5;

  color_palette_db dut (
    .CLK_100(CLK_100), .RESET(RESET), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_READDATA(AVL_READDATA), .AVL_WRITE(AVL_WRITE),
    .AVL_READ(AVL_READ), .AVL_CS(AVL_CS), .frame_start(frame_start), .pix_valid(pix_valid),
    .palette(palette), .color_index(color_index), .rgb(rgb), .rgb_valid(rgb_valid),
    .rgb_transparent(rgb_transparent), .commit_done(commit_done)
  );

  color_palette_db #(.NUM_PALETTES(5)) dut5 (
    .CLK_100(CLK_100), .RESET(RESET), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_READDATA(rd5), .AVL_WRITE(AVL_WRITE),
    .AVL_READ(AVL_READ), .AVL_CS(AVL_CS), .frame_start(frame_start), .pix_valid(pix_valid),
    .palette(palette), .color_index(color_index), .rgb(rgb5), .rgb_valid(rgb_valid5),
    .rgb_transparent(trans5), .commit_done(done5)
  );

  always #5 CLK_100 = ~CLK_100;

  // Model of the 8-palette instance.
  int unsigned m_shadow [NP][NC];
  int unsigned m_active [NP][NC];
  bit          m_pending;
  bit          m_trans;
  int unsigned m_count;
  int unsigned m_rd;
  int unsigned m_rgb;
  bit          m_valid;
  bit          m_tout;
  bit          m_done;

  int checks   = 0;
  int failures = 0;

  function automatic void model_reset();
    foreach (m_shadow[p, c]) begin
      m_shadow[p][c] = 0;
      m_active[p][c] = 0;
    end
    m_pending = 0; m_trans = 0; m_count = 0;
    m_rd = 0; m_rgb = 0; m_valid = 0; m_tout = 0; m_done = 0;
  endfunction

  // Apply one clock of the current inputs to the model and the DUT, then idle the strobes.
  task automatic tick();
    logic [2:0]  pal;
    logic [1:0]  idx;
    logic [4:0]  off;
    logic        wr;
    logic        rd;
    logic        cmt;
    int unsigned mask;
    pal  = AVL_ADDR[4:2];
    idx  = AVL_ADDR[1:0];
    off  = AVL_ADDR[4:0];
    wr   = AVL_CS && AVL_WRITE;
    rd   = AVL_CS && AVL_READ && !AVL_WRITE;
    cmt  = frame_start && m_pending;
    mask = {8'h00, {8{AVL_BYTE_EN[2]}}, {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};

    m_valid = pix_valid;
    if (pix_valid) begin
      m_rgb  = m_active[palette][color_index];
      m_tout = m_trans && (color_index == 2'd0);
    end
    if (rd) begin
      if (!AVL_ADDR[5])       m_rd = m_shadow[pal][idx];
      else if (off == 5'd0)   m_rd = {30'b0, m_trans, m_pending};
      else if (off == 5'd1)   m_rd = m_count;
      else                    m_rd = 0;
    end
    m_done = cmt;
    if (cmt) begin
      m_active  = m_shadow;
      m_pending = 0;
      m_count   = (m_count + 1) % 256;
    end
    if (wr && !AVL_ADDR[5])
      m_shadow[pal][idx] = (m_shadow[pal][idx] & ~mask) | (AVL_WRITEDATA & mask);
    if (wr && AVL_ADDR[5] && off == 5'd0 && AVL_BYTE_EN[0]) begin
      if (AVL_WRITEDATA[0]) m_pending = 1;
      m_trans = AVL_WRITEDATA[1];
    end

    @(posedge CLK_100);
    #1;
    AVL_CS = 0; AVL_WRITE = 0; AVL_READ = 0; frame_start = 0; pix_valid = 0;
  endtask

  task automatic avl_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    tick();
  endtask

  task automatic avl_read(input logic [5:0] a);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = a;
    tick();
  endtask

  task automatic lookup(input logic [2:0] p, input logic [1:0] i);
    pix_valid = 1; palette = p; color_index = i;
    tick();
  endtask

  task automatic frame();
    frame_start = 1;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1;
    repeat (2) @(posedge CLK_100);
    #1;
    model_reset();
    if (AVL_READDATA !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", AVL_READDATA); end
    checks++;
    if (rgb !== 24'd0 || rgb_valid !== 1'b0 || rgb_transparent !== 1'b0 || commit_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rgb=%h v=%b t=%b d=%b exp all 0", rgb, rgb_valid, rgb_transparent, commit_done);
    end
    checks++;
    @(negedge CLK_100);
    RESET = 0;
    lookup(3'd3, 2'd2);
    if (rgb !== 24'h000000 || rgb_valid !== 1'b1) begin
      failures++; $display("FAIL reset_lookup got rgb=%h v=%b exp rgb=000000 v=1", rgb, rgb_valid);
    end
    checks++;
  endtask

  task automatic test_entry_write();
    avl_write({1'b0, 3'd2, 2'd1}, 32'h00FF8040, 4'b0101);
    avl_read({1'b0, 3'd2, 2'd1});
    if (AVL_READDATA !== 32'h00FF0040 || AVL_READDATA !== m_rd) begin
      failures++; $display("FAIL entry_byte_en got=%h exp=%h", AVL_READDATA, 32'h00FF0040);
    end
    checks++;
    lookup(3'd2, 2'd1);
    if (rgb !== 24'h0) begin failures++; $display("FAIL lookup_before_commit got=%h exp=0", rgb); end
    checks++;
  endtask

  task automatic test_commit();
    avl_write(6'h20, 32'h1, 4'h1);
    frame();
    if (commit_done !== 1'b1) begin failures++; $display("FAIL commit_pulse got=%b exp=1", commit_done); end
    checks++;
    lookup(3'd2, 2'd1);
    if (commit_done !== 1'b0) begin failures++; $display("FAIL commit_single got=%b exp=0", commit_done); end
    checks++;
    if (rgb !== 24'hFF0040) begin failures++; $display("FAIL lookup_after_commit got=%h exp=ff0040", rgb); end
    checks++;
    avl_read(6'h21);
    if (AVL_READDATA !== 32'h1) begin failures++; $display("FAIL status_one got=%h exp=1", AVL_READDATA); end
    checks++;
    avl_read(6'h20);
    if (AVL_READDATA[0] !== 1'b0) begin failures++; $display("FAIL ctrl_pending_clear got=%b exp=0", AVL_READDATA[0]); end
    checks++;
  endtask

  task automatic test_same_cycle();
    int unsigned old;
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 6'h20; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'h1;
    frame_start = 1;
    tick();
    if (commit_done !== 1'b0) begin failures++; $display("FAIL same_cycle_request got=%b exp=0", commit_done); end
    checks++;
    frame();
    if (commit_done !== 1'b1) begin failures++; $display("FAIL deferred_commit got=%b exp=1", commit_done); end
    checks++;
    avl_read(6'h21);
    if (AVL_READDATA !== 32'h2 || AVL_READDATA !== m_rd) begin
      failures++; $display("FAIL status_two got=%h exp=2", AVL_READDATA);
    end
    checks++;
    old = m_active[0][0];
    avl_write(6'h20, 32'h1, 4'h1);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 6'h00; AVL_WRITEDATA = 32'h00123456; AVL_BYTE_EN = 4'hF;
    frame_start = 1;
    tick();
    lookup(3'd0, 2'd0);
    if (rgb !== 24'(old)) begin failures++; $display("FAIL commit_cycle_write got=%h exp=%h", rgb, 24'(old)); end
    checks++;
    avl_write(6'h20, 32'h1, 4'h1);
    frame();
    lookup(3'd0, 2'd0);
    if (rgb !== 24'h123456) begin failures++; $display("FAIL next_commit_write got=%h exp=123456", rgb); end
    checks++;
  endtask

  task automatic test_transparency();
    avl_write(6'h20, 32'h2, 4'h1);
    lookup(3'($urandom), 2'd0);
    if (rgb_transparent !== 1'b1) begin failures++; $display("FAIL trans_idx0 got=%b exp=1", rgb_transparent); end
    checks++;
    if (rgb !== 24'(m_rgb)) begin failures++; $display("FAIL trans_rgb got=%h exp=%h", rgb, 24'(m_rgb)); end
    checks++;
    lookup(3'($urandom), 2'd1);
    if (rgb_transparent !== 1'b0) begin failures++; $display("FAIL trans_idx1 got=%b exp=0", rgb_transparent); end
    checks++;
    color_index = 2'd0;
    tick();
    if (rgb_valid !== 1'b0 || rgb_transparent !== 1'b0 || rgb !== 24'(m_rgb)) begin
      failures++; $display("FAIL idle_hold got v=%b t=%b rgb=%h exp v=0 t=0 rgb=%h", rgb_valid, rgb_transparent, rgb, 24'(m_rgb));
    end
    checks++;
  endtask

  task automatic test_pal_limit();
    logic [31:0] v;
    v = $urandom;
    avl_write({1'b0, 3'd6, 2'd1}, $urandom, 4'hF);
    avl_read({1'b0, 3'd6, 2'd1});
    if (rd5 !== 32'd0) begin failures++; $display("FAIL pal5_oob_read got=%h exp=0", rd5); end
    checks++;
    avl_write({1'b0, 3'd4, 2'd3}, v, 4'hF);
    avl_read({1'b0, 3'd4, 2'd3});
    if (rd5 !== (v & 32'h00FFFFFF)) begin failures++; $display("FAIL pal5_last_read got=%h exp=%h", rd5, v & 32'h00FFFFFF); end
    checks++;
    lookup(3'd6, 2'd1);
    if (rgb5 !== 24'd0 || rgb_valid5 !== 1'b1) begin
      failures++; $display("FAIL pal5_oob_lookup got rgb=%h v=%b exp rgb=0 v=1", rgb5, rgb_valid5);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      AVL_CS        = ($urandom_range(0, 3) != 0);
      AVL_WRITE     = $urandom_range(0, 1);
      AVL_READ      = $urandom_range(0, 1);
      AVL_WRITEDATA = $urandom;
      AVL_BYTE_EN   = 4'($urandom);
      AVL_ADDR      = ($urandom_range(0, 3) == 0) ? {1'b1, 5'($urandom_range(0, 3))} : {1'b0, 5'($urandom)};
      frame_start   = ($urandom_range(0, 5) == 0);
      pix_valid     = $urandom_range(0, 1);
      palette       = 3'($urandom);
      color_index   = 2'($urandom);
      tick();
      if (AVL_READDATA !== m_rd) begin failures++; $display("FAIL rnd_readdata cyc=%0d got=%h exp=%h", n, AVL_READDATA, m_rd); end
      checks++;
      if (rgb !== 24'(m_rgb)) begin failures++; $display("FAIL rnd_rgb cyc=%0d got=%h exp=%h", n, rgb, 24'(m_rgb)); end
      checks++;
      if (rgb_valid !== m_valid || rgb_transparent !== m_tout) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got v=%b t=%b exp v=%b t=%b", n, rgb_valid, rgb_transparent, m_valid, m_tout);
      end
      checks++;
      if (commit_done !== m_done) begin failures++; $display("FAIL rnd_commit cyc=%0d got=%b exp=%b", n, commit_done, m_done); end
      checks++;
    end
  endtask

  task automatic test_wrap();
    int unsigned n;
    n = 256 - m_count;
    for (int unsigned i = 0; i < n; i++) begin
      if (i == n - 1) begin
        avl_read(6'h21);
        if (AVL_READDATA !== 32'd255) begin failures++; $display("FAIL status_255 got=%h exp=ff", AVL_READDATA); end
        checks++;
      end
      avl_write(6'h20, 32'h1, 4'h1);
      frame();
    end
    avl_read(6'h21);
    if (AVL_READDATA !== 32'd0 || m_rd != 0) begin failures++; $display("FAIL status_wrap got=%h exp=0", AVL_READDATA); end
    checks++;
  endtask

  task automatic test_reset_pending();
    avl_write({1'b0, 3'd1, 2'd2}, 32'h00ABCDEF, 4'hF);
    avl_read({1'b0, 3'd1, 2'd2});
    lookup(3'd0, 2'd0);
    avl_write(6'h20, 32'h3, 4'h1);
    RESET = 1;
    #2;
    model_reset();
    if (AVL_READDATA !== 32'd0 || rgb !== 24'd0 || commit_done !== 1'b0) begin
      failures++; $display("FAIL async_reset got rd=%h rgb=%h d=%b exp all 0", AVL_READDATA, rgb, commit_done);
    end
    checks++;
    @(negedge CLK_100);
    RESET = 0;
    frame();
    if (commit_done !== 1'b0) begin failures++; $display("FAIL reset_drops_pending got=%b exp=0", commit_done); end
    checks++;
    avl_read(6'h20);
    if (AVL_READDATA !== 32'd0) begin failures++; $display("FAIL ctrl_after_reset got=%h exp=0", AVL_READDATA); end
    checks++;
    avl_read({1'b0, 3'd1, 2'd2});
    if (AVL_READDATA !== 32'd0) begin failures++; $display("FAIL shadow_after_reset got=%h exp=0", AVL_READDATA); end
    checks++;
  endtask

  initial begin
    AVL_ADDR = '0; AVL_WRITEDATA = '0; AVL_BYTE_EN = '0;
    AVL_WRITE = 0; AVL_READ = 0; AVL_CS = 0;
    frame_start = 0; pix_valid = 0; palette = '0; color_index = '0;
    test_reset();
    test_entry_write();
    test_commit();
    test_same_cycle();
    test_transparency();
    test_pal_limit();
    test_random();
    test_wrap();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/color_palette_db.md
Name: color_palette_db

Overview:
Parametrised, double-buffered successor to the 8x4 palette register file. Software writes a shadow bank over Avalon-MM and requests a commit. The shadow is copied into the active bank atomically at the next frame_start, so palette edits never tear mid-frame. The pixel side does a registered lookup with a valid strobe and optional index-0 transparency. It sits between the sprite/tile renderer and the VGA output stage.

Parameters:
NUM_PALETTES, 8, palettes held (1..64); PAL_W = max(1, clog2(NUM_PALETTES))
COLORS_PER_PALETTE, 4, entries per palette, power of two (2..16); IDX_W = clog2(COLORS_PER_PALETTE)
CHANNEL_W, 8, bits per R/G/B channel (4..10); COLOR_W = 3*CHANNEL_W

Ports:
CLK_100  in  1  sole clock
RESET  in  1  asynchronous, active-high reset
AVL_ADDR  in  PAL_W+IDX_W+1  MSB=0: entry {palette,index}; MSB=1: control space, low bits = register offset
AVL_WRITEDATA  in  32  write data; colour at [COLOR_W-1:0] as {R,G,B}
AVL_BYTE_EN  in  4  per-byte-lane write enables
AVL_READDATA  out  32  read data, fixed latency 1
AVL_WRITE, AVL_READ, AVL_CS  in  1 each  Avalon-MM strobes
frame_start  in  1  one-cycle pulse at vblank start
pix_valid  in  1  lookup request
palette  in  PAL_W  palette select
color_index  in  IDX_W  entry select
rgb  out  COLOR_W  looked-up colour, registered
rgb_valid  out  1  rgb qualifier
rgb_transparent  out  1  entry is transparent
commit_done  out  1  one-cycle pulse when a commit is applied

Behaviour:
- Reset (async assert): shadow and active banks = 0; AVL_READDATA = 0; rgb = 0; rgb_valid = 0; rgb_transparent = 0; commit_done = 0; pending = 0; trans_en = 0; commit_count = 0.
- Entry write (CS & WRITE, MSB=0): update shadow[pal][idx] bit-by-bit. Bit b is written iff AVL_BYTE_EN[b/8] is set, for b < COLOR_W. Bits at or above COLOR_W are ignored.
- Writes to an entry with pal >= NUM_PALETTES are ignored. Reads of such an entry return 0.
- Entry read (CS & READ, MSB=0): AVL_READDATA <= zero-extended shadow entry on the next edge. Reads return the shadow bank, not the active bank.
- AVL_READDATA holds its value when no read is in progress. WRITE and READ asserted together: WRITE wins and AVL_READDATA holds.
- Control space, offset 0 (CTRL):
  - bit0 write-1 sets pending; write-0 has no effect.
  - bit1 = trans_en, read/write.
  - Read returns {30'b0, trans_en, pending}.
  - Byte lane 0 gates both bits.
- Control space, offset 1 (STATUS): read-only; [7:0] = commit_count. Writes are ignored.
- Other control offsets read 0 and ignore writes.
- Commit: on a frame_start cycle with pending already 1 (registered value):
  - active <= shadow, as it stood before any same-cycle write;
  - pending <= 0;
  - commit_count += 1, wrapping 255 -> 0;
  - commit_done = 1 for exactly that following cycle.
- A same-cycle shadow write lands in shadow only and is visible at the next commit.
- A commit request written in the same cycle as frame_start is not consumed by that frame_start; it becomes pending for the next one.
- frame_start with pending = 0 does nothing.
- Repeated commit requests before frame_start collapse into one commit.
- Lookup, latency 1:
  - rgb_valid <= pix_valid every cycle.
  - When pix_valid = 1: rgb <= active[palette][color_index], or 0 if palette >= NUM_PALETTES; rgb_transparent <= trans_en & (color_index == 0).
  - When pix_valid = 0: rgb and rgb_transparent hold.
- Lookup in the same cycle as a commit returns the old active value. The new value is visible from the next cycle.
- Reset asserted mid-frame or with pending = 1 clears everything and drops the pending commit.
- Implementation: registers only (copy is single-cycle), no RAM inference. All logic sits in one always_ff with async reset, plus combinational decode.

Test Plan:
- Reset -> rgb = 0, rgb_valid = 0, AVL_READDATA = 0. Lookup (pal 3, idx 2) -> rgb 0x000000 one cycle after pix_valid.
- Write 0x00FF8040 to entry (2,1) with BYTE_EN = 4'b0101, readback -> 0x00FF0040 one cycle after READ. Lookup (2,1) still -> 0 (no commit yet).
- Write CTRL = 1, then frame_start pulse -> commit_done pulses once, lookup (2,1) -> 0xFF0040, STATUS reads 0x01, CTRL bit0 reads 0.
- Write CTRL bit0 in the same cycle as frame_start -> no commit on that frame; next frame_start commits; commit_count reaches 2. Shadow write to (0,0) = 0x123456 in the commit cycle -> active (0,0) unchanged until the following commit.
- trans_en = 1, lookup idx 0 -> rgb_transparent = 1; idx 1 -> 0. With NUM_PALETTES = 5: write to pal 6 ignored, lookup pal 6 -> rgb 0.
- 256 commits -> commit_count wraps to 0x00. Assert RESET while pending = 1 -> pending 0, and a subsequent frame_start causes no commit_done.
